// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with DECODE, LATCH, SCAN and PULSE modes.
// Each output bit is its own registered cell fed from a shared next-state select.

module onehot_decoder_cell #(
  parameter int SEL_W = 3,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic [SEL_W-1:0] idx,
  output logic             q
);
  localparam logic [SEL_W-1:0] MY_IDX = SEL_W'(IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= on && (idx == MY_IDX);
  end
endmodule

module onehot_decoder_seq #(
  parameter int SEL_W    = 3,
  parameter int OUT_W    = 2**SEL_W,
  parameter int SCAN_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             load,
  output logic [OUT_W-1:0] out,
  output logic [SEL_W-1:0] idx,
  output logic             active,
  output logic             wrap
);
  localparam int               DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] IDX_TOP = {SEL_W{1'b1}};

  typedef enum logic [1:0] {M_DECODE, M_LATCH, M_SCAN, M_PULSE} mode_e;

  typedef struct packed {
    logic             on;
    logic [SEL_W-1:0] idx;
    logic             wrap;
    logic [DIV_W-1:0] div;
  } st_t;

  st_t st_q, nxt;

  // Defaults: hold the select, clear wrap and divider; only SCAN advances div.
  always_comb begin
    nxt      = st_q;
    nxt.wrap = 1'b0;
    nxt.div  = '0;
    if (!en) begin
      nxt.on  = 1'b0;
      nxt.idx = '0;
    end else begin
      case (mode_e'(mode))
        M_DECODE: begin
          nxt.on  = 1'b1;
          nxt.idx = sel;
        end
        M_LATCH: begin
          if (load) begin
            nxt.on  = 1'b1;
            nxt.idx = sel;
          end
        end
        M_SCAN: begin
          if (load) begin
            nxt.on  = 1'b1;
            nxt.idx = sel;
          end else if (!st_q.on) begin
            nxt.on  = 1'b1;
            nxt.idx = '0;
          end else if (st_q.div == DIV_MAX) begin
            nxt.idx  = st_q.idx + 1'b1;
            nxt.wrap = (st_q.idx == IDX_TOP);
          end else begin
            nxt.div = DIV_W'(st_q.div + 1'b1);
          end
        end
        M_PULSE: begin
          nxt.on  = load;
          nxt.idx = load ? sel : '0;
        end
        default: nxt = st_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= '0;
    else     st_q <= nxt;
  end

  // One registered cell per output bit, so out, idx and active update together.
  genvar gi;
  generate
    for (gi = 0; gi < OUT_W; gi++) begin : g_cell
      onehot_decoder_cell #(.SEL_W(SEL_W), .IDX(gi)) u_cell (
        .clk (clk),
        .rst (rst),
        .on  (nxt.on),
        .idx (nxt.idx),
        .q   (out[gi])
      );
    end
  endgenerate

  assign idx    = st_q.idx;
  assign active = st_q.on;
  assign wrap   = st_q.wrap;
endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Randomized + scenario bench for onehot_decoder_seq against a position/dwell model.
module tb_onehot_decoder_seq;
  localparam int SEL_W    = 3;
  localparam int OUT_W    = 8;
  localparam int SCAN_DIV = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b1;
  logic [1:0]       mode = 2'b00;
  logic [SEL_W-1:0] sel = '0;
  logic             load = 1'b0;
  logic [OUT_W-1:0] out;
  logic [SEL_W-1:0] idx;
  logic             active;
  logic             wrap;

  int n_chk = 0;
  int n_pass = 0;

  // model: lit position (-1 = none), dwell count at that position, wrap flag
  int m_pos = -1;
  int m_div = 0;
  bit m_wrap = 1'b0;

  onehot_decoder_seq #(.SEL_W(SEL_W), .SCAN_DIV(SCAN_DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .sel    (sel),
    .load   (load),
    .out    (out),
    .idx    (idx),
    .active (active),
    .wrap   (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_edge();
    if (rst || !en) begin
      m_pos = -1; m_div = 0; m_wrap = 0;
    end else begin
      m_wrap = 0;
      case (mode)
        2'b00: begin m_pos = int'(sel); m_div = 0; end
        2'b01: begin if (load) m_pos = int'(sel); m_div = 0; end
        2'b10: begin
          if (load) begin m_pos = int'(sel); m_div = 0; end
          else if (m_pos < 0) begin m_pos = 0; m_div = 0; end
          else if (m_div + 1 >= SCAN_DIV) begin
            m_wrap = (m_pos == OUT_W - 1);
            m_pos  = (m_pos + 1) % OUT_W;
            m_div  = 0;
          end else m_div++;
        end
        default: begin m_pos = load ? int'(sel) : -1; m_div = 0; end
      endcase
    end
  endtask

  task automatic compare_all(input string tag);
    logic [31:0] eo;
    eo = (m_pos < 0) ? 32'd0 : (32'd1 << m_pos);
    chk({tag, ".out"},    32'(out), eo);
    chk({tag, ".idx"},    32'(idx), (m_pos < 0) ? 32'd0 : 32'(m_pos));
    chk({tag, ".active"}, 32'(active), 32'(m_pos >= 0));
    chk({tag, ".wrap"},   32'(wrap), 32'(m_wrap));
    chk({tag, ".onehot"}, 32'($countones(out) <= 1), 32'd1);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  initial begin
    int wraps;
    int guard;

    // reset and DECODE sweep
    #2;
    chk("reset.out", 32'(out), 32'd0);
    step("rst"); step("rst");
    rst = 1'b0;
    for (int s = 0; s < OUT_W; s++) begin
      sel = SEL_W'(s);
      step("decode");
      chk("decode.direct", 32'(out), 32'd1 << s);
    end

    // LATCH hold then en low
    mode = 2'b01; sel = 3'd5; load = 1'b1; step("latch_ld");
    load = 1'b0; sel = 3'd2;
    for (int k = 0; k < 3; k++) begin
      step("latch_hold");
      chk("latch.direct", 32'(out), 32'h20);
    end
    en = 1'b0; step("en_low");
    chk("en_low.direct", 32'(out), 32'h00);
    en = 1'b1;

    // SCAN walk from zero, one wrap per 16-cycle period
    mode = 2'b10; step("scan_start");
    chk("scan_start.direct", 32'(out), 32'h01);
    wraps = 0;
    for (int k = 0; k < OUT_W * SCAN_DIV; k++) begin
      step("scan");
      if (wrap) wraps++;
    end
    chk("scan.wraps_per_period", 32'(wraps), 32'd1);

    // SCAN jump mid-scan
    guard = 0;
    while (m_pos != 2 && guard < 40) begin step("scan_seek"); guard++; end
    chk("scan_seek.reached", 32'(m_pos == 2), 32'd1);
    load = 1'b1; sel = 3'd6; step("scan_jump");
    chk("jump.direct", 32'(out), 32'h40);
    load = 1'b0;
    for (int k = 0; k < 6; k++) step("scan_after_jump");

    // PULSE strobes
    mode = 2'b11; load = 1'b1; sel = 3'd3; step("pulse1");
    load = 1'b0; step("pulse_gap");
    load = 1'b1; sel = 3'd1; step("pulse2");
    sel = 3'd7; step("pulse3");
    chk("pulse3.direct", 32'(out), 32'h80);
    load = 1'b0; step("pulse_end");

    // async reset mid-scan at 0x10
    mode = 2'b10; guard = 0;
    while (m_pos != 4 && guard < 40) begin step("scan_seek2"); guard++; end
    chk("scan_seek2.reached", 32'(m_pos == 4), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst.out", 32'(out), 32'd0);
    chk("async_rst.active", 32'(active), 32'd0);
    m_pos = -1; m_div = 0; m_wrap = 0;
    step("in_rst");
    rst = 1'b0;
    step("post_rst");
    chk("post_rst.direct", 32'(out), 32'h01);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      rst  = ($urandom_range(0, 99) < 2);
      en   = ($urandom_range(0, 99) < 92);
      if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
      sel  = SEL_W'($urandom);
      load = ($urandom_range(0, 99) < 25);
      if (rst) begin m_pos = -1; m_div = 0; m_wrap = 0; end
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/onehot_decoder_seq.md
# onehot_decoder_seq

Registered, parametrised binary-to-one-hot decoder with four operating modes: continuous decode, latched decode, scanning (walking one-hot with programmable dwell) and single-cycle strobe. It is the sequential successor to the team's combinational 3-to-8 decoder. It drives row/column selects, LED/digit scan lines and channel strobes where a glitch-free, clock-aligned one-hot select is required.

## Interface
- SEL_W, 3, select width; must be ≥1.
- OUT_W, 2**SEL_W, output width (derived; do not override).
- SCAN_DIV, 1, cycles each position is held in SCAN mode; must be ≥1.

- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  global enable; low forces outputs to zero on the next edge.
- mode  input  2  00 DECODE, 01 LATCH, 10 SCAN, 11 PULSE.
- sel  input  SEL_W  binary select index.
- load  input  1  capture strobe for LATCH, PULSE and SCAN-jump.
- out  output  OUT_W  registered one-hot select, or all-zero.
- idx  output  SEL_W  binary index of the asserted out bit; 0 when out is zero.
- active  output  1  registered; equals |out.
- wrap  output  1  one-cycle pulse on a SCAN wrap from bit OUT_W-1 to bit 0.

## Operation
- Internal state: out register, idx register, divider counter div (0..SCAN_DIV-1), wrap register.
- Priority at each edge: rst > en low > mode behaviour.
- en low: out=0, idx=0, active=0, wrap=0, div=0.
- DECODE (00): out <= 1<<sel every cycle; load ignored; div=0.
- LATCH (01): load=1 gives out <= 1<<sel. load=0 holds out, including all-zero. div=0.
- SCAN (10):
  - load=1: out <= 1<<sel, div=0, wrap=0. The jump has priority over advance.
  - Otherwise, if out==0: out <= bit 0 immediately, div=0.
  - Otherwise, if div==SCAN_DIV-1: out rotates left by one (bit OUT_W-1 goes to bit 0) and div=0. wrap=1 only on the OUT_W-1 to 0 rotation.
  - Otherwise: div <= div+1 and out holds.
- PULSE (11): load=1 gives out <= 1<<sel. load=0 gives out <= 0. Each strobe is therefore exactly one cycle wide, and back-to-back loads give back-to-back strobes. div=0.
- Leaving SCAN clears div. out is retained across a mode change until the new mode's rule rewrites it. Example: DECODE to LATCH with load=0 holds the last decoded value.
- idx and active are always consistent with out in the same cycle. Both are registered alongside out, not decoded from it combinationally.
- Invariant: popcount(out) ≤ 1 in every cycle.

## Timing
- Reset values: out=0, idx=0, active=0, wrap=0, div=0. Reset takes effect immediately on rst assertion, independent of clk.
- Reset mid-scan: the next scan after release starts at bit 0, with no wrap pulse.
- Latency: 1 cycle from sampled sel/mode/load/en to out/idx/active.
- In SCAN, each position is held for exactly SCAN_DIV cycles. Exception: a load jump restarts the dwell at the new position.
- A full SCAN period is OUT_W*SCAN_DIV cycles. wrap is high for exactly 1 cycle per period, coincident with out==1.
- When SCAN_DIV=1, out advances every cycle.
- Simultaneous en low and load: en wins and out=0.
- Simultaneous SCAN entry and load: the load jump applies.

## Test plan
All scenarios use SEL_W=3 (OUT_W=8) and SCAN_DIV=2 unless noted.

- **Reset/DECODE:** hold rst, then release with en=1, mode=00, sel sweeping 0..7 one per cycle. Required: out=0x00 during reset, then out=0x01,0x02,…,0x80 each one cycle after its sel, with idx=sel and active=1.
- **LATCH hold and en:** mode=01, load pulse with sel=5, then sel changes to 2 with load=0. Required: out stays 0x20. Then drop en for one cycle. Required: out=0x00, idx=0, active=0.
- **SCAN walk and wrap:** mode=10 from out=0. Required: out=0x01 one cycle later, then each bit held 2 cycles through 0x80, then back to 0x01 with wrap=1 for exactly one cycle. Period is 16 cycles.
- **SCAN jump:** mid-scan at out=0x04, load=1 with sel=6. Required: out=0x40 next cycle, held 2 cycles, then 0x80, then 0x01 with wrap=1.
- **PULSE:** mode=11, load high for 1 cycle with sel=3, then for 2 consecutive cycles with sel=1 then sel=7. Required: 0x08 for 1 cycle then 0x00, then 0x02 followed by 0x80 with no gap, then 0x00.
- **Async reset mid-scan:** assert rst between clock edges at out=0x10. Required: out=0x00 immediately, before the next edge. After release with mode=10, out=0x01 with wrap=0.
